// File: rtl/snn_spike_encoder.sv
// Rate encoder: latches one frame of N_CH intensities and replays it for WIN_LEN beats,
// firing each channel from a per-channel phase accumulator carry.
module snn_spike_encoder #(
   parameter int N_CH    = 4,
   parameter int VAL_W   = 4,
   parameter int WIN_LEN = 16,
   parameter int SPK_AMP = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_CH*VAL_W-1:0]   in_data,
   input  logic                    stall,
   output logic                    spk_valid,
   output logic [N_CH-1:0]         spk,
   output logic [N_CH*VAL_W-1:0]   spk_nib,
   output logic                    frame_done,
   output logic                    busy
);

   // Handshake: a frame transfers on a rising edge where in_valid && in_ready.
   // The source keeps in_valid/in_data stable until that edge; in_ready is high only in IDLE.

   localparam int                 CNT_W     = $clog2(WIN_LEN) + 1;
   localparam logic [0:0]         ST_IDLE   = 1'b0;
   localparam logic [0:0]         ST_RUN    = 1'b1;
   localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(WIN_LEN - 1);
   localparam logic [VAL_W-1:0]   AMP       = VAL_W'(SPK_AMP);

   logic [0:0]         r_state;
   logic [VAL_W-1:0]   r_val [N_CH];
   logic [VAL_W-1:0]   r_acc [N_CH];
   logic [CNT_W-1:0]   r_beat_cnt;

   logic               w_beat;
   logic               w_last;
   logic [VAL_W:0]     w_sum [N_CH];

   always_comb begin
      w_beat  = (r_state == ST_RUN) && !stall;
      w_last  = w_beat && (r_beat_cnt == LAST_BEAT);
      spk     = '0;
      spk_nib = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_sum[c] = {1'b0, r_acc[c]} + {1'b0, r_val[c]};
         // The accumulator carry is the spike; nothing leaves the block on a stalled cycle.
         spk[c] = w_beat && w_sum[c][VAL_W];
         spk_nib[c*VAL_W +: VAL_W] = (w_beat && w_sum[c][VAL_W]) ? AMP : '0;
      end
   end

   assign in_ready   = (r_state == ST_IDLE);
   assign busy       = (r_state == ST_RUN);
   assign spk_valid  = w_beat;
   assign frame_done = w_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
         for (int c = 0; c < N_CH; c++) begin
            r_val[c] <= '0;
            r_acc[c] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_state    <= ST_RUN;
                  r_beat_cnt <= '0;
                  for (int c = 0; c < N_CH; c++) begin
                     r_val[c] <= in_data[c*VAL_W +: VAL_W];
                     r_acc[c] <= '0;
                  end
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                  for (int c = 0; c < N_CH; c++) begin
                     r_acc[c] <= w_sum[c][VAL_W-1:0];
                  end
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_spike_encoder.sv
// Directed bench for snn_spike_encoder: table of frames with hand-computed spike counts,
// plus hand-written sequences for back-to-back frames, mid-frame reset and spk_nib.
module tb_snn_spike_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        stall;
   logic        spk_valid;
   logic [3:0]  spk;
   logic [15:0] spk_nib;
   logic        frame_done;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [15:0] g_nib_b0;
   logic [15:0] g_nib_b1;
   logic [3:0]  g_spk_b1;

   typedef struct {
      logic [15:0] data;
      logic [31:0] stall_mask;
      logic [19:0] exp_cnt;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [8];

   snn_spike_encoder #(
      .N_CH(4), .VAL_W(4), .WIN_LEN(16), .SPK_AMP(15)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .stall(stall), .spk_valid(spk_valid), .spk(spk), .spk_nib(spk_nib),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Beat b fires channel c iff floor((b+1)*v/16) exceeds floor(b*v/16).
   function automatic logic [3:0] model_spk(input logic [15:0] d, input int b);
      logic [3:0] r;
      int v;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         v = int'(d[c*4 +: 4]);
         r[c] = (((b + 1) * v) / 16) != ((b * v) / 16);
      end
      return r;
   endfunction

   function automatic logic [15:0] model_nib(input logic [3:0] s);
      logic [15:0] n;
      n = '0;
      for (int c = 0; c < 4; c++) n[c*4 +: 4] = s[c] ? 4'hF : 4'h0;
      return n;
   endfunction

   // Called at the negedge of the first RUN cycle; returns after the frame_done cycle.
   task automatic run_window(input logic [15:0] d, input logic [31:0] mask,
                             output int cyc, output int beats, output logic [19:0] cnts);
      int cnt [4];
      logic done;
      logic [3:0] e;
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      beats = 0;
      cyc   = 0;
      done  = 1'b0;
      while (!done && cyc < 40) begin
         stall = (cyc < 32) ? mask[cyc] : 1'b0;
         #1;
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_ready", 32'(in_ready), 32'd0);
         chk("spk_valid_vs_stall", 32'(spk_valid), 32'(!stall));
         if (spk_valid) begin
            e = model_spk(d, beats);
            chk("beat_spk", 32'(spk), 32'(e));
            chk("beat_nib", 32'(spk_nib), 32'(model_nib(e)));
            chk("beat_frame_done", 32'(frame_done), 32'(beats == 15));
            if (beats == 0) g_nib_b0 = spk_nib;
            if (beats == 1) begin
               g_nib_b1 = spk_nib;
               g_spk_b1 = spk;
            end
            for (int c = 0; c < 4; c++) if (spk[c]) cnt[c]++;
            beats++;
            if (frame_done) done = 1'b1;
         end else begin
            chk("stall_spk", 32'(spk), 32'd0);
            chk("stall_nib", 32'(spk_nib), 32'd0);
            chk("stall_frame_done", 32'(frame_done), 32'd0);
         end
         cyc++;
         if (!done) @(negedge clk);
      end
      stall = 1'b0;
      chk("window_finished", 32'(done), 32'd1);
      cnts = {5'(cnt[3]), 5'(cnt[2]), 5'(cnt[1]), 5'(cnt[0])};
   endtask

   task automatic do_frame(input logic [15:0] d, input logic [31:0] mask,
                           input logic [19:0] exp_cnt, input int exp_cyc);
      int cyc;
      int beats;
      logic [19:0] cnts;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk("accept_ready", 32'(in_ready), 32'd1);
      chk("accept_no_spk", 32'(spk_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      run_window(d, mask, cyc, beats, cnts);
      chk("frame_beats", 32'(beats), 32'd16);
      chk("frame_cycles", 32'(cyc), 32'(exp_cyc));
      chk("frame_counts", 32'(cnts), 32'(exp_cnt));
      @(negedge clk);
      #1;
      chk("post_idle_ready", 32'(in_ready), 32'd1);
      chk("post_idle_busy", 32'(busy), 32'd0);
      chk("post_idle_valid", 32'(spk_valid), 32'd0);
   endtask

   initial begin
      int cyc;
      int beats;
      logic [19:0] cnts;

      vecs[0] = '{16'hF810, 32'h0000_0000, {5'd15, 5'd8,  5'd1,  5'd0},  16};
      vecs[1] = '{16'hF810, 32'h0004_0038, {5'd15, 5'd8,  5'd1,  5'd0},  20};
      vecs[2] = '{16'h4444, 32'h0000_0000, {5'd4,  5'd4,  5'd4,  5'd4},  16};
      vecs[3] = '{16'hF0F0, 32'h0000_0000, {5'd15, 5'd0,  5'd15, 5'd0},  16};
      vecs[4] = '{16'h0000, 32'h0000_0000, {5'd0,  5'd0,  5'd0,  5'd0},  16};
      vecs[5] = '{16'hFFFF, 32'h0000_0000, {5'd15, 5'd15, 5'd15, 5'd15}, 16};
      vecs[6] = '{16'h1234, 32'h0000_0000, {5'd1,  5'd2,  5'd3,  5'd4},  16};
      vecs[7] = '{16'hA5C3, 32'h0000_0001, {5'd10, 5'd5,  5'd12, 5'd3},  17};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 16'h0;
      stall    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_ready", 32'(in_ready), 32'd1);
      chk("reset_valid", 32'(spk_valid), 32'd0);
      chk("reset_spk", 32'(spk), 32'd0);
      chk("reset_nib", 32'(spk_nib), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         do_frame(vecs[i].data, vecs[i].stall_mask, vecs[i].exp_cnt, vecs[i].exp_cyc);
         if (vecs[i].data == 16'hF0F0) begin
            chk("f0f0_beat0_nib", 32'(g_nib_b0), 32'h0000);
            chk("f0f0_beat1_spk", 32'(g_spk_b1), 32'hA);
            chk("f0f0_beat1_nib", 32'(g_nib_b1), 32'hF0F0);
         end
      end

      // Back-to-back frames with in_valid held high throughout.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hF810;
      #1;
      chk("b2b_accept1_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_data = 16'h4444;
      run_window(16'hF810, 32'h0, cyc, beats, cnts);
      chk("b2b_f1_cycles", 32'(cyc), 32'd16);
      chk("b2b_f1_counts", 32'(cnts), 32'({5'd15, 5'd8, 5'd1, 5'd0}));
      @(negedge clk);
      #1;
      chk("b2b_gap_ready", 32'(in_ready), 32'd1);
      chk("b2b_gap_valid", 32'(spk_valid), 32'd0);
      chk("b2b_gap_busy", 32'(busy), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      run_window(16'h4444, 32'h0, cyc, beats, cnts);
      chk("b2b_f2_cycles", 32'(cyc), 32'd16);
      chk("b2b_f2_counts", 32'(cnts), 32'({5'd4, 5'd4, 5'd4, 5'd4}));

      // Reset asserted on beat 7 aborts the frame.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hF810;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      #1;
      chk("pre_reset_beat7_valid", 32'(spk_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_valid", 32'(spk_valid), 32'd0);
      chk("midrst_spk", 32'(spk), 32'd0);
      chk("midrst_nib", 32'(spk_nib), 32'd0);
      chk("midrst_frame_done", 32'(frame_done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      do_frame(16'h4444, 32'h0, {5'd4, 5'd4, 5'd4, 5'd4}, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
